// File: rtl/ripple_pipe_adder_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder/subtractor.
// Holds the single-bit full adder reused by every slice and the parameter legality rule.
package ripple_pipe_adder_pkg;

  typedef struct packed {
    logic carry;
    logic sum;
  } fa_out_t;

  function automatic fa_out_t full_add(input logic a, input logic b, input logic cin);
    fa_out_t r;
    r.sum   = a ^ b ^ cin;
    r.carry = (a & b) | (cin & (a ^ b));
    return r;
  endfunction

  function automatic bit cfg_legal(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/ripple_pipe_adder_slice.sv
// One W-bit ripple slice: operand skew in, registered ripple result, sum skew out.
// Only the most-significant slice reports signed overflow; the others drive 0.
module adder_slice
  import ripple_pipe_adder_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter int unsigned InDelay  = 0,
  parameter int unsigned OutDelay = 0,
  parameter bit          IsLast   = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [W-1:0] a_s;
  logic [W-1:0] b_s;
  logic [W-1:0] sum_d;
  logic [W-1:0] sum_q;
  logic [W:0]   c;
  logic         ovf_d;
  logic         cout_q;
  logic         ovf_q;

  if (InDelay == 0) begin : g_in_direct
    assign a_s = a;
    assign b_s = b;
  end else begin : g_in_skew
    logic [W-1:0] a_q [InDelay];
    logic [W-1:0] b_q [InDelay];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(InDelay); i++) begin
          a_q[i] <= '0;
          b_q[i] <= '0;
        end
      end else if (en) begin
        a_q[0] <= a;
        b_q[0] <= b;
        for (int i = 1; i < int'(InDelay); i++) begin
          a_q[i] <= a_q[i-1];
          b_q[i] <= b_q[i-1];
        end
      end
    end

    assign a_s = a_q[InDelay-1];
    assign b_s = b_q[InDelay-1];
  end

  always_comb begin
    c     = '0;
    sum_d = '0;
    c[0]  = cin;
    for (int i = 0; i < int'(W); i++) begin
      {c[i+1], sum_d[i]} = full_add(a_s[i], b_s[i], c[i]);
    end
  end

  // Carry into the MSB vs carry out of it; meaningful only for the top slice.
  assign ovf_d = IsLast ? (c[W] ^ c[W-1]) : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      sum_q  <= sum_d;
      cout_q <= c[W];
      ovf_q  <= ovf_d;
    end
  end

  assign cout = cout_q;
  assign ovf  = ovf_q;

  if (OutDelay == 0) begin : g_out_direct
    assign sum = sum_q;
  end else begin : g_out_skew
    logic [W-1:0] s_q [OutDelay];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(OutDelay); i++) begin
          s_q[i] <= '0;
        end
      end else if (en) begin
        s_q[0] <= sum_q;
        for (int i = 1; i < int'(OutDelay); i++) begin
          s_q[i] <= s_q[i-1];
        end
      end
    end

    assign sum = s_q[OutDelay-1];
  end

endmodule

// File: rtl/ripple_pipe_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready flow control.
// The whole pipeline advances together; a stalled head freezes every register.
module ripple_pipe_adder
  import ripple_pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int unsigned W = WIDTH / STAGES;

  if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
    $error("ripple_pipe_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic              advance;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_s;
  logic [STAGES-1:0] ovf_s;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // Subtraction is A + ~B + 1, so Sub forces the initial carry high.
  assign b_eff   = Sub ? ~B : B;
  assign cin_eff = Sub | Cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (advance) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < int'(STAGES); k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic slice_cin;

    if (k == 0) begin : g_first
      assign slice_cin = cin_eff;
    end else begin : g_rest
      assign slice_cin = carry_s[k-1];
    end

    adder_slice #(
      .W       (W),
      .InDelay (k),
      .OutDelay(STAGES - 1 - k),
      .IsLast  (k == STAGES - 1)
    ) u_slice (
      .clk (clk),
      .rst (rst),
      .en  (advance),
      .a   (A[k*W +: W]),
      .b   (b_eff[k*W +: W]),
      .cin (slice_cin),
      .sum (Sum[k*W +: W]),
      .cout(carry_s[k]),
      .ovf (ovf_s[k])
    );
  end

  assign Carry    = carry_s[STAGES-1];
  // Lower slices tie their flag to 0, so the OR is just the top slice's overflow.
  assign Overflow = |ovf_s;

endmodule

// File: tb/tb_ripple_pipe_adder.sv
// Self-checking bench: random and directed beats against an arithmetic model of the pipeline.
module tb_ripple_pipe_adder;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STAGES = 4;

  typedef struct packed {
    logic        ovf;
    logic        carry;
    logic [31:0] sum;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, in_ready, Cin, Sub, out_valid, out_ready, Carry, Overflow;
  logic [WIDTH-1:0] A, B, Sum;

  logic       in_valid8, in_ready8, cin8, sub8, out_valid8, carry8, ovf8;
  logic       out_ready8;
  logic [7:0] a8, b8, sum8;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  ripple_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .Cin(Cin), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum),
    .Carry(Carry), .Overflow(Overflow)
  );

  ripple_pipe_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .A(a8), .B(b8),
    .Cin(cin8), .Sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .Sum(sum8),
    .Carry(carry8), .Overflow(ovf8)
  );

  function automatic res_t ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
    res_t        r;
    logic [32:0] mask;
    logic [32:0] full;
    logic [31:0] am;
    logic [31:0] beff;
    mask   = (33'd1 << w) - 33'd1;
    am     = a & mask[31:0];
    beff   = sub ? (~b & mask[31:0]) : (b & mask[31:0]);
    full   = {1'b0, am} + {1'b0, beff} + {32'd0, (sub ? 1'b1 : cin)};
    r.sum  = full[31:0] & mask[31:0];
    r.carry = full[w];
    r.ovf  = (am[w-1] == beff[w-1]) && (r.sum[w-1] != am[w-1]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Pipeline model: STAGES slots that shift together unless the head is held.
  logic m_v   [STAGES];
  res_t m_res [STAGES];
  logic m_acc;
  int   m_retired   = 0;
  int   dut_retired = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) m_v[i] <= 1'b0;
      m_acc <= 1'b0;
    end else if (m_v[STAGES-1] && !out_ready) begin
      m_acc <= 1'b0;
    end else begin
      m_v[0]   <= in_valid;
      m_res[0] <= ref_add(WIDTH, {16'h0, A}, {16'h0, B}, Cin, Sub);
      for (int i = 1; i < int'(STAGES); i++) begin
        m_v[i]   <= m_v[i-1];
        m_res[i] <= m_res[i-1];
      end
      m_acc <= in_valid;
      if (m_v[STAGES-1]) m_retired <= m_retired + 1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !(m_v[STAGES-1] && !out_ready)});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_v[STAGES-1]});
      if (m_v[STAGES-1]) begin
        check("sum", {16'h0, Sum}, m_res[STAGES-1].sum);
        check("carry", {31'd0, Carry}, {31'd0, m_res[STAGES-1].carry});
        check("overflow", {31'd0, Overflow}, {31'd0, m_res[STAGES-1].ovf});
      end
    end
  end

  // Handshake count sampled just before each rising edge.
  always @(negedge clk) begin
    #4;
    if (!rst && out_valid && out_ready) dut_retired++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic [15:0] es, input logic ec,
                          input logic eo, input string nm);
    @(negedge clk);
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (STAGES - 1) @(posedge clk);
    #2;
    check({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({nm, "_sum"}, {16'h0, Sum}, {16'h0, es});
    check({nm, "_carry"}, {31'd0, Carry}, {31'd0, ec});
    check({nm, "_ovf"}, {31'd0, Overflow}, {31'd0, eo});
  endtask

  initial begin
    res_t        r;
    res_t        held;
    int          base;
    logic [7:0]  ta, tb8;
    logic        tc, ts;

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'h0, Sum}, 32'd0);
    check("rst_carry", {31'd0, Carry}, 32'd0);
    check("rst_ovf", {31'd0, Overflow}, 32'd0);
    cmp_en = 1'b1;

    r = ref_add(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
    check("pin_add_wrap", r, {1'b0, 1'b1, 32'h0000});
    r = ref_add(16, 32'h8000, 32'h0001, 1'b0, 1'b1);
    check("pin_sub_ovf", r, {1'b1, 1'b1, 32'h7FFF});
    r = ref_add(8, 32'h7F, 32'h01, 1'b0, 1'b0);
    check("pin_add8_ovf", r, {1'b1, 1'b0, 32'h0080});

    directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    directed(16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_borrow");

    // 100 back-to-back beats with the sink always ready.
    repeat (2) @(negedge clk);
    base = dut_retired;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom);
      Cin = 1'($urandom_range(0, 1)); Sub = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (STAGES + 2) @(negedge clk);
    check("b2b_count", dut_retired - base, 32'd100);

    // Fill the pipe, then hold the sink off for five cycles.
    base = dut_retired;
    for (int n = 0; n < int'(STAGES); n++) begin
      @(negedge clk);
      in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom);
      Cin = 1'($urandom_range(0, 1)); Sub = 1'($urandom_range(0, 1));
      if (n == 0) held = ref_add(16, {16'h0, A}, {16'h0, B}, Cin, Sub);
    end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #2;
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_sum", {16'h0, Sum}, held.sum);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (STAGES + 2) @(negedge clk);
    check("stall_count", dut_retired - base, STAGES + 1);

    // Random traffic with random back-pressure; unaccepted beats are held.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!(in_valid && !m_acc)) begin
        in_valid = ($urandom_range(0, 99) < 70);
        A = 16'($urandom); B = 16'($urandom);
        Cin = 1'($urandom_range(0, 1)); Sub = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 99) < 60);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (STAGES + 4) @(negedge clk);
    check("retire_total", dut_retired, m_retired);

    // Reset with three beats in flight.
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom); Sub = 1'b0; Cin = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #2;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sum", {16'h0, Sum}, 32'd0);
    check("mid_rst_carry", {31'd0, Carry}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    base = dut_retired;
    @(posedge clk);
    #2;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (STAGES + 4) @(negedge clk);
    check("mid_rst_no_stale", dut_retired - base, 32'd0);

    // Single-stage 8-bit instance.
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0;
    @(posedge clk);
    #2;
    check("w8_valid", {31'd0, out_valid8}, 32'd1);
    check("w8_sum", {24'h0, sum8}, 32'h80);
    check("w8_carry", {31'd0, carry8}, 32'd0);
    check("w8_ovf", {31'd0, ovf8}, 32'd1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      ta = 8'($urandom); tb8 = 8'($urandom);
      tc = 1'($urandom_range(0, 1)); ts = 1'($urandom_range(0, 1));
      a8 = ta; b8 = tb8; cin8 = tc; sub8 = ts;
      r = ref_add(8, {24'h0, ta}, {24'h0, tb8}, tc, ts);
      @(posedge clk);
      #2;
      check("w8_rand_sum", {24'h0, sum8}, r.sum);
      check("w8_rand_flags", {30'd0, carry8, ovf8}, {30'd0, r.carry, r.ovf});
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    @(posedge clk);
    #2;
    check("w8_idle_valid", {31'd0, out_valid8}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
